// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM multiplexer/demultiplexer pair.
// Holds the channel count, channel-index type and framing state enum.
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [CH_W-1:0] ch_idx_t;

    function automatic logic is_last_ch(input ch_idx_t c);
        return c == ch_idx_t'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/tdm_demux_8to1_if.sv
// Serial-in / parallel-out bundle for the TDM demultiplexer.
// master drives the serial side; slave is the demultiplexer.
interface tdm_demux_8to1_if
    import tdm_pkg::*;
#(
    parameter int W = 8
);

    logic [W-1:0]        din;
    logic                din_valid;
    logic                frame_sync;
    logic [NUM_CH*W-1:0] dout;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, locked, sync_err
    );

endinterface

// File: rtl/tdm_ch_counter.sv
// Wrapping channel counter with load-to-1, clear and terminal count.
// Priority: clear, then load, then increment.
module tdm_ch_counter
    import tdm_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr_i,
    input  logic    load1_i,
    input  logic    inc_i,
    output ch_idx_t ch_o,
    output logic    tc_o
);

    ch_idx_t ch_q;
    ch_idx_t ch_d;

    always_comb begin
        ch_d = ch_q;
        unique case (1'b1)
            clr_i:   ch_d = '0;
            load1_i: ch_d = ch_idx_t'(1);
            inc_i:   ch_d = ch_q + ch_idx_t'(1);
            default: ch_d = ch_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    assign ch_o = ch_q;
    assign tc_o = is_last_ch(ch_q);

endmodule

// File: rtl/tdm_demux_8to1.sv
// 8:1 TDM demultiplexer: stages serial samples, emits whole frames.
// Define TDM_DEMUX_SYNC_CHECK_EN to re-align and flag misplaced frame_sync.
module tdm_demux_8to1
    import tdm_pkg::*;
#(
    parameter int W = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_8to1_if.slave   tdm
);

    state_e              state_q;
    state_e              state_d;
    logic [W-1:0]        stg_q [NUM_CH];
    logic [NUM_CH*W-1:0] dout_q;
    logic [NUM_CH*W-1:0] dout_d;
    logic                fv_q;
    logic                fv_d;
    logic                err_q;
    logic                err_d;

    logic    stg_we;
    ch_idx_t stg_idx;
    logic    cnt_clr;
    logic    cnt_load;
    logic    cnt_inc;
    ch_idx_t ch;
    logic    ch_tc;
    logic    resync;

    tdm_ch_counter u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load),
        .inc_i   (cnt_inc),
        .ch_o    (ch),
        .tc_o    (ch_tc)
    );

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    assign resync = tdm.frame_sync && (ch != '0);
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        stg_we   = 1'b0;
        stg_idx  = ch;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (tdm.din_valid) begin
                    if (tdm.frame_sync) begin
                        state_d  = LOCKED;
                        stg_we   = 1'b1;
                        stg_idx  = '0;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (tdm.din_valid) begin
                    if (resync) begin
                        err_d    = 1'b1;
                        stg_we   = 1'b1;
                        stg_idx  = '0;
                        cnt_load = 1'b1;
                    end else begin
                        stg_we  = 1'b1;
                        cnt_inc = 1'b1;
                        if (ch_tc) begin
                            // last channel bypasses staging
                            fv_d = 1'b1;
                            for (int k = 0; k < NUM_CH - 1; k++) begin
                                dout_d[k*W +: W] = stg_q[k];
                            end
                            dout_d[(NUM_CH-1)*W +: W] = tdm.din;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            dout_q  <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                stg_q[k] <= '0;
            end
        end else if (stg_we) begin
            stg_q[stg_idx] <= tdm.din;
        end
    end

    assign tdm.dout        = dout_q;
    assign tdm.frame_valid = fv_q;
    assign tdm.locked      = (state_q == LOCKED);
    assign tdm.sync_err    = err_q;

endmodule
